// File: rtl/i2s_rx.sv
// i2s_rx
// Receives codec ADC data over I2S, oversampled in the clk domain, and hands
// stereo sample pairs to the core with a valid/ready handshake.
//
// Ports
//   clk         system clock (at least 4x BCLK)
//   reset_n     asynchronous active-low reset
//   i2s_bclk    codec bit clock (asynchronous)
//   i2s_lrclk   codec word select, 0 = left, 1 = right (asynchronous)
//   i2s_data    codec serial data, MSB first (asynchronous)
//   left_out    left sample, two's complement
//   right_out   right sample, two's complement
//   out_valid   sample pair available
//   out_ready   consumer accepts the pair
//   overflow    sticky: a pair was overwritten before it was accepted
//   short_word  sticky: a delivered word had fewer than WIDTH bits
//
// Sync state machine
//   state     | meaning
//   ST_UNSYNC | after reset; waiting for the first word boundary
//   ST_WAIT_L | aligned to boundaries; waiting for a complete left word
//   ST_RUN    | left word held, each right word completes a frame

module i2s_rx #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i2s_bclk,
    input  logic             i2s_lrclk,
    input  logic             i2s_data,
    output logic [WIDTH-1:0] left_out,
    output logic [WIDTH-1:0] right_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overflow,
    output logic             short_word
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_UNSYNC = 2'd0,
        ST_WAIT_L = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    state_t           r_state;
    logic [2:0]       r_bclk_sync;
    logic [1:0]       r_ws_sync;
    logic [1:0]       r_d_sync;
    logic             r_ws_prev;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] r_left_hold;

    logic             w_bclk_rise;
    logic             w_ws;
    logic             w_d;
    logic             w_take;
    logic [WIDTH-1:0] w_shreg_nxt;
    logic [CW-1:0]    w_cnt_nxt;
    logic [CW-1:0]    w_shamt;
    logic [WIDTH-1:0] w_word;
    logic             w_short;

    // All three pins go through the same depth so ws/data stay aligned with
    // the detected BCLK edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bclk_sync <= '0;
            r_ws_sync   <= '0;
            r_d_sync    <= '0;
        end else begin
            r_bclk_sync <= {r_bclk_sync[1:0], i2s_bclk};
            r_ws_sync   <= {r_ws_sync[0], i2s_lrclk};
            r_d_sync    <= {r_d_sync[0], i2s_data};
        end
    end

    assign w_bclk_rise = r_bclk_sync[1] & ~r_bclk_sync[2];
    assign w_ws        = r_ws_sync[1];
    assign w_d         = r_d_sync[1];

    // Bits beyond WIDTH are dropped, so the top WIDTH bits of a long word stay.
    assign w_take      = (r_cnt < CW'(WIDTH));
    assign w_shreg_nxt = w_take ? {r_shreg[WIDTH-2:0], w_d} : r_shreg;
    assign w_cnt_nxt   = w_take ? (r_cnt + CW'(1)) : r_cnt;

    // Left-justify a short word; w_cnt_nxt is at least 1 on a boundary.
    assign w_shamt     = CW'(WIDTH) - w_cnt_nxt;
    assign w_word      = w_shreg_nxt << w_shamt;
    assign w_short     = (w_cnt_nxt < CW'(WIDTH));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_UNSYNC;
            r_ws_prev   <= 1'b0;
            r_cnt       <= '0;
            r_shreg     <= '0;
            r_left_hold <= '0;
            left_out    <= '0;
            right_out   <= '0;
            out_valid   <= 1'b0;
            overflow    <= 1'b0;
            short_word  <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if (w_bclk_rise) begin
                r_ws_prev <= w_ws;
                if (w_ws != r_ws_prev) begin
                    // Boundary rise: this bit is the last slot of the old word.
                    r_cnt   <= '0;
                    r_shreg <= '0;
                    case (r_state)
                        ST_UNSYNC: begin
                            r_state <= ST_WAIT_L;
                        end
                        ST_WAIT_L: begin
                            // Discarded words are never flagged as short.
                            if (!r_ws_prev) begin
                                r_left_hold <= w_word;
                                r_state     <= ST_RUN;
                                if (w_short) begin
                                    short_word <= 1'b1;
                                end
                            end
                        end
                        ST_RUN: begin
                            if (w_short) begin
                                short_word <= 1'b1;
                            end
                            if (!r_ws_prev) begin
                                r_left_hold <= w_word;
                            end else begin
                                left_out  <= r_left_hold;
                                right_out <= w_word;
                                out_valid <= 1'b1;
                                if (out_valid && !out_ready) begin
                                    overflow <= 1'b1;
                                end
                            end
                        end
                        default: begin
                            r_state <= ST_UNSYNC;
                        end
                    endcase
                end else begin
                    r_cnt   <= w_cnt_nxt;
                    r_shreg <= w_shreg_nxt;
                end
            end
        end
    end

endmodule

// File: doc/i2s_rx.md
# i2s_rx

I2S receiver for the DE2-115 codec ADC path (line-in/mic). It is the receive-side counterpart of the I2S transmitter in the audio output chain. The codec is bus master and drives BCLK, ADCLRCK and ADCDAT. This block oversamples those three signals in the system clock domain, deserialises MSB-first I2S words, and presents stereo sample pairs to the core on a valid/ready handshake.

## Interface
- `WIDTH`, default 16: sample width in bits per channel. Legal range 8..32.
- `clk`  in  1  system clock. Must be ≥ 4× the BCLK frequency.
- `reset_n`  in  1  asynchronous, active-low reset.
- `i2s_bclk`  in  1  codec bit clock, asynchronous to `clk`.
- `i2s_lrclk`  in  1  codec ADC word select. 0 = left, 1 = right. Asynchronous.
- `i2s_data`  in  1  codec ADC serial data. Asynchronous.
- `left_out`  out  WIDTH  left sample, two's complement.
- `right_out`  out  WIDTH  right sample, two's complement.
- `out_valid`  out  1  sample pair available.
- `out_ready`  in  1  consumer accepts the pair.
- `overflow`  out  1  sticky. A frame was overwritten before it was accepted.
- `short_word`  out  1  sticky. A word had fewer than WIDTH bits.

## Operation
- **Synchronisation**
  - `i2s_bclk`, `i2s_lrclk` and `i2s_data` each pass through an identical 2-FF synchroniser, so all three stay aligned.
  - A third BCLK stage provides rising-edge detection (`bclk_rise`). All capture happens only on `bclk_rise`.
- **Per-rise state**
  - On each `bclk_rise`, sample `ws` and `d`.
  - `ws_prev` holds `ws` from the previous rise.
  - `cnt` counts captured bits, saturating at WIDTH.
- **Capture rule (I2S: MSB is one BCLK after the WS transition)**
  - **`ws == ws_prev`:** if `cnt < WIDTH`, shift `d` into `shreg` LSB-first-in (MSB ends up on top) and increment `cnt`. Otherwise ignore the bit.
  - **`ws != ws_prev` (boundary rise):**
    - This bit is the last slot of the old word. Shift it in under the same `cnt < WIDTH` rule.
    - Then close the word for channel `ws_prev`. Resulting word = `shreg` left-justified, LSBs zero-filled when `cnt_final < WIDTH`.
    - If `cnt_final < WIDTH`, set `short_word`.
    - Reset `cnt` to 0 and `shreg` to 0.
- **Sync state machine (`UNSYNC` → `WAIT_L` → `RUN`)**
  - `UNSYNC`: after reset. At the first boundary rise, go to `WAIT_L` and discard the closed word, because its start was not seen.
  - `WAIT_L`:
    - A closed right word is discarded.
    - A closed left word goes to a `left_hold` register; go to `RUN`.
  - `RUN`:
    - A closed left word goes to `left_hold`.
    - A closed right word completes the frame: `left_out <= left_hold`, `right_out <= word`, `out_valid <= 1`.
- **Handshake**
  - A transfer occurs in any cycle with `out_valid && out_ready`. In the next cycle `out_valid` = 0, unless a frame completes in the same cycle.
  - A frame completing while `out_valid && !out_ready` sets `overflow`. The outputs take the new frame and `out_valid` stays 1.
  - A frame completing in the same cycle as an accept: the new frame loads and `out_valid` stays 1. `overflow` is not set.
  - `left_out` and `right_out` are stable whenever `out_valid = 1` and no new frame completes.
- **Sticky flags:** `overflow` and `short_word` clear only on reset.
- **Extra bits:** words longer than WIDTH keep the top WIDTH bits; the remaining bits are ignored without error.

## Timing
- **Reset values:** `left_out = 0`, `right_out = 0`, `out_valid = 0`, `overflow = 0`, `short_word = 0`. Internal state: `UNSYNC`, `cnt = 0`, synchronisers = 0.
- **Reset mid-word** drops all partial data. Resync requires a full left word followed by a right word.
- **Sampling point:** a bit is sampled 3 `clk` cycles after the BCLK rising edge at the pins (2 sync + 1 edge stage).
- **Latency:** `out_valid` rises 1 `clk` after the `bclk_rise` that closes the right word. That is ≤ 4 `clk` after the pin edge, plus up to 1 `clk` of synchroniser uncertainty.
- **Input constraint:** BCLK high and low phases must each be ≥ 2 `clk` periods. Data and LRCLK must be stable around BCLK rise; the codec changes them on BCLK fall.
- **Throughput:** one frame per LRCLK period. The consumer must accept within one frame period to avoid `overflow`.

## Test plan
- **Basic frame, WIDTH=16, 32 BCLK/frame:** send L=0x8001, R=0x7FFE after one sync frame → `out_valid` pulses once with `left_out = 0x8001`, `right_out = 0x7FFE`, `out_ready = 1`.
- **Reset / startup:** assert `reset_n = 0` mid-right-word, release, stream L=0x1234, R=0xABCD → the first valid pair is exactly 0x1234/0xABCD, with no partial frame emitted. All outputs read 0 during reset.
- **Long words (24 BCLK per channel):** send L=0x123456, R=0xFEDCBA with WIDTH=16 → `left_out = 0x1234`, `right_out = 0xFEDC`, `short_word = 0`.
- **Short word (12 BCLK per channel):** send L=0xABC, R=0x123 with WIDTH=16 → `left_out = 0xABC0`, `right_out = 0x1230`, `short_word = 1` and it stays 1.
- **Backpressure:** hold `out_ready = 0` across two frames (0x0001/0x0002, then 0x0003/0x0004) → outputs show 0x0003/0x0004, `overflow = 1`, `out_valid` stays 1. Raise `out_ready` for 1 cycle → `out_valid = 0`.
- **Accept on completion edge:** `out_ready` is high exactly in the cycle the next frame completes → the new frame loads, `out_valid` stays 1, `overflow` stays 0.
